spi_stream_ctrl: RTL and testbench

Command/stream controller between the SPI slave byte interface and the 8-bit sample FIFO. It decodes command bytes from the SPI master and gates PCM capture. It schedules FIFO reads so each SPI byte slot carries a sample byte, a status byte or fill. It replaces ad-hoc read-on-busy logic with a deterministic, length-bounded burst protocol.

---
 rtl/spi_stream_pkg.sv | 44 ++++
 rtl/spi_stream_ctrl_edge_sync.sv | 24 ++
 rtl/spi_stream_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_spi_stream_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_stream_pkg.sv
// Shared types and constants for the SPI command/stream controller.
// Optional watchdog is enabled by defining SPI_STREAM_WATCHDOG_EN.

package spi_stream_pkg;

    typedef enum logic [1:0] {
        CMD    = 2'd0,
        LEN    = 2'd1,
        STREAM = 2'd2
    } stream_state_t;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_STOP   = 8'h02;
    localparam logic [7:0] CMD_FLUSH  = 8'h03;
    localparam logic [7:0] CMD_READ   = 8'h10;
    localparam logic [7:0] CMD_STATUS = 8'h20;

    localparam int STAT_CAPTURE   = 7;
    localparam int STAT_OVERFLOW  = 6;
    localparam int STAT_UNDERFLOW = 5;
    localparam int STAT_CMD_ERR   = 4;
    localparam int STAT_FULL      = 3;
    localparam int STAT_EMPTY     = 2;

    function automatic logic [7:0] pack_status(
        input logic capture,
        input logic overflow,
        input logic underflow,
        input logic cmd_err,
        input logic full,
        input logic empty
    );
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_CAPTURE]   = capture;
        s[STAT_OVERFLOW]  = overflow;
        s[STAT_UNDERFLOW] = underflow;
        s[STAT_CMD_ERR]   = cmd_err;
        s[STAT_FULL]      = full;
        s[STAT_EMPTY]     = empty;
        return s;
    endfunction

endpackage

// File: rtl/spi_stream_ctrl_edge_sync.sv
// Three-flop synchroniser with a rising-edge detector on the two oldest stages.
// Reusable for any slow asynchronous level such as SPI busy or chip select.

module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = (sync_q[2:1] == 2'b01);

endmodule

// File: rtl/spi_stream_ctrl.sv
// SPI command decoder and slot scheduler feeding sample, status or fill bytes to the SPI slave.
// Define SPI_STREAM_WATCHDOG_EN to abort stalled LEN/STREAM phases after TIMEOUT_CYCLES.

module spi_stream_ctrl
    import spi_stream_pkg::*;
#(
    parameter logic [7:0]  FILL_BYTE      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_busy_i,
    input  logic       spi_rx_valid_i,
    input  logic [7:0] spi_rx_data_i,
    output logic [7:0] spi_tx_data_o,
    output logic       spi_tx_valid_o,
    input  logic       fifo_empty_i,
    input  logic       fifo_full_i,
    input  logic [7:0] fifo_rd_data_i,
    output logic       fifo_rd_en_o,
    output logic       fifo_clr_o,
    input  logic       fifo_overflow_i,
    output logic       capture_en_o,
    output logic [1:0] state_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic slot_edge;

    edge_sync u_busy_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_busy_i),
        .rise_o  (slot_edge)
    );

    stream_state_t state_q, state_d;
    logic [8:0]    remaining_q, remaining_d;
    logic          capture_q, capture_d;
    logic          clr_q, clr_d;
    logic          pending_q, pending_d;
    logic          ovf_stk_q, ovf_stk_d;
    logic          unf_stk_q, unf_stk_d;
    logic          err_stk_q, err_stk_d;

    // Slot pipeline: stage 1 is E+1 (pop issued), stage 2 is E+2 (FIFO data valid).
    logic          rd_en_q, rd_en_d;
    logic          s1_valid_q, s1_valid_d;
    logic [7:0]    s1_byte_q, s1_byte_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s2_fifo_q, s2_fifo_d;
    logic [7:0]    s2_byte_q, s2_byte_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

`ifdef SPI_STREAM_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        capture_d   = capture_q;
        clr_d       = 1'b0;
        pending_d   = pending_q;
        ovf_stk_d   = ovf_stk_q;
        unf_stk_d   = unf_stk_q;
        err_stk_d   = err_stk_q;
        rd_en_d     = 1'b0;
        s1_valid_d  = 1'b0;
        s1_byte_d   = s1_byte_q;
        s2_valid_d  = s1_valid_q;
        s2_fifo_d   = rd_en_q;
        s2_byte_d   = s1_byte_q;
        tx_valid_d  = s2_valid_q;
        tx_data_d   = tx_data_q;

        if (slot_edge) begin
            s1_valid_d = 1'b1;
            s1_byte_d  = FILL_BYTE;
            if (pending_q) begin
                s1_byte_d = pack_status(capture_q, ovf_stk_q, unf_stk_q, err_stk_q,
                                        fifo_full_i, fifo_empty_i);
                pending_d = 1'b0;
                ovf_stk_d = 1'b0;
                unf_stk_d = 1'b0;
                err_stk_d = 1'b0;
            end else if (state_q == STREAM) begin
                if (!fifo_empty_i) begin
                    rd_en_d = 1'b1;
                end else begin
                    unf_stk_d = 1'b1;
                end
            end
        end

        if (s2_valid_q) begin
            tx_data_d = s2_fifo_q ? fifo_rd_data_i : s2_byte_q;
        end

        // Command handling follows the slot logic so a same-cycle set beats the status clear.
        if (spi_rx_valid_i) begin
            unique case (state_q)
                CMD: begin
                    unique case (spi_rx_data_i)
                        CMD_START:  capture_d = 1'b1;
                        CMD_STOP:   capture_d = 1'b0;
                        CMD_FLUSH:  clr_d     = 1'b1;
                        CMD_READ:   state_d   = LEN;
                        CMD_STATUS: pending_d = 1'b1;
                        default:    err_stk_d = 1'b1;
                    endcase
                end
                LEN: begin
                    remaining_d = (spi_rx_data_i == 8'h00) ? 9'd256 : {1'b0, spi_rx_data_i};
                    state_d     = STREAM;
                end
                STREAM: begin
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        state_d = CMD;
                    end
                end
                default: state_d = CMD;
            endcase
        end

        if (fifo_overflow_i) begin
            ovf_stk_d = 1'b1;
        end

`ifdef SPI_STREAM_WATCHDOG_EN
        wd_d = wd_q;
        if (state_q == CMD || spi_rx_valid_i) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            wd_d        = '0;
            state_d     = CMD;
            err_stk_d   = 1'b1;
            remaining_d = 9'd0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CMD;
            remaining_q <= 9'd0;
            capture_q   <= 1'b0;
            clr_q       <= 1'b0;
            pending_q   <= 1'b0;
            ovf_stk_q   <= 1'b0;
            unf_stk_q   <= 1'b0;
            err_stk_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_byte_q   <= 8'h00;
            s2_valid_q  <= 1'b0;
            s2_fifo_q   <= 1'b0;
            s2_byte_q   <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            capture_q   <= capture_d;
            clr_q       <= clr_d;
            pending_q   <= pending_d;
            ovf_stk_q   <= ovf_stk_d;
            unf_stk_q   <= unf_stk_d;
            err_stk_q   <= err_stk_d;
            rd_en_q     <= rd_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_byte_q   <= s1_byte_d;
            s2_valid_q  <= s2_valid_d;
            s2_fifo_q   <= s2_fifo_d;
            s2_byte_q   <= s2_byte_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

`ifdef SPI_STREAM_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign spi_tx_data_o  = tx_data_q;
    assign spi_tx_valid_o = tx_valid_q;
    assign fifo_rd_en_o   = rd_en_q;
    assign fifo_clr_o     = clr_q;
    assign capture_en_o   = capture_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_spi_stream_ctrl.sv
// Directed bench for spi_stream_ctrl with a behavioural FIFO and SPI slot driver.
// Define SPI_STREAM_WATCHDOG_EN for both bench and RTL to exercise the watchdog.

module tb_spi_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_busy_i = 1'b0;
    logic       spi_rx_valid_i = 1'b0;
    logic [7:0] spi_rx_data_i = 8'h00;
    logic [7:0] spi_tx_data_o;
    logic       spi_tx_valid_o;
    logic       fifo_empty_i;
    logic       fifo_full_i;
    logic [7:0] fifo_rd_data_i = 8'h00;
    logic       fifo_rd_en_o;
    logic       fifo_clr_o;
    logic       fifo_overflow_i = 1'b0;
    logic       capture_en_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    spi_stream_ctrl #(
        .FILL_BYTE      (8'h00),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_busy_i      (spi_busy_i),
        .spi_rx_valid_i  (spi_rx_valid_i),
        .spi_rx_data_i   (spi_rx_data_i),
        .spi_tx_data_o   (spi_tx_data_o),
        .spi_tx_valid_o  (spi_tx_valid_o),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_full_i     (fifo_full_i),
        .fifo_rd_data_i  (fifo_rd_data_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .fifo_clr_o      (fifo_clr_o),
        .fifo_overflow_i (fifo_overflow_i),
        .capture_en_o    (capture_en_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, flush drops everything queued.
    logic [7:0]  fifo_mem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign fifo_empty_i = (rd_ptr == wr_ptr);
    assign fifo_full_i  = ((wr_ptr - rd_ptr) >= 16);

    always @(posedge clk) begin
        if (fifo_clr_o) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en_o && (rd_ptr != wr_ptr)) begin
            fifo_rd_data_i <= fifo_mem[rd_ptr % 64];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // One SPI byte slot; records what the DUT did relative to the busy rise.
    logic [7:0] s_tx;
    int         s_ntx, s_txat, s_nrd, s_rdat;

    task automatic slot(input logic [7:0] rx);
        s_tx = 8'hxx; s_ntx = 0; s_txat = 0; s_nrd = 0; s_rdat = 0;
        spi_busy_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (spi_tx_valid_o) begin s_ntx++; s_tx = spi_tx_data_o; s_txat = k; end
            if (fifo_rd_en_o)   begin s_nrd++; s_rdat = k; end
        end
        spi_rx_valid_i = 1'b1;
        spi_rx_data_i  = rx;
        @(negedge clk);
        spi_rx_valid_i = 1'b0;
        spi_busy_i     = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_tx_data_o, spi_tx_valid_o, fifo_rd_en_o, fifo_clr_o, capture_en_o, state_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%h v=%b rd=%b clr=%b cap=%b st=%0d, want all 0",
                     spi_tx_data_o, spi_tx_valid_o, fifo_rd_en_o, fifo_clr_o, capture_en_o, state_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state_o !== 2'd0 || capture_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: st=%0d cap=%b, want st=0 cap=0", state_o, capture_en_o);
        end
    endtask

    task automatic test_start_stop;
        slot(8'h01);
        checks++;
        if (s_tx !== 8'h00 || s_ntx !== 1 || s_txat !== 5 || s_nrd !== 0 || capture_en_o !== 1'b1) begin
            errors++;
            $display("FAIL start: tx=%h n=%0d at=%0d rd=%0d cap=%b, want tx=00 n=1 at=5 rd=0 cap=1",
                     s_tx, s_ntx, s_txat, s_nrd, capture_en_o);
        end
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h00 || s_ntx !== 1 || s_txat !== 5 || s_nrd !== 0 || capture_en_o !== 1'b0) begin
            errors++;
            $display("FAIL stop: tx=%h n=%0d at=%0d rd=%0d cap=%b, want tx=00 n=1 at=5 rd=0 cap=0",
                     s_tx, s_ntx, s_txat, s_nrd, capture_en_o);
        end
    endtask

    task automatic test_burst;
        logic [7:0] exp_bytes [3];
        exp_bytes = '{8'hA0, 8'hA1, 8'hA2};
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        slot(8'h10);
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL burst_len_state: st=%0d, want 1", state_o);
        end
        slot(8'h03);
        checks++;
        if (state_o !== 2'd2 || s_nrd !== 0) begin
            errors++; $display("FAIL burst_stream_state: st=%0d rd=%0d, want st=2 rd=0", state_o, s_nrd);
        end
        for (int i = 0; i < 3; i++) begin
            slot(8'hFF);
            checks++;
            if (s_tx !== exp_bytes[i] || s_ntx !== 1 || s_txat !== 5 || s_nrd !== 1 || s_rdat !== 3) begin
                errors++;
                $display("FAIL burst_byte%0d: tx=%h n=%0d at=%0d rd=%0d rdat=%0d, want tx=%h n=1 at=5 rd=1 rdat=3",
                         i, s_tx, s_ntx, s_txat, s_nrd, s_rdat, exp_bytes[i]);
            end
        end
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL burst_end_state: st=%0d, want 0", state_o);
        end
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h00 || s_nrd !== 0 || (wr_ptr - rd_ptr) !== 1 || fifo_mem[rd_ptr % 64] !== 8'hA3) begin
            errors++;
            $display("FAIL burst_after: tx=%h rd=%0d left=%0d head=%h, want tx=00 rd=0 left=1 head=a3",
                     s_tx, s_nrd, wr_ptr - rd_ptr, fifo_mem[rd_ptr % 64]);
        end
        slot(8'h03);
        checks++;
        if (fifo_empty_i !== 1'b1 || s_tx !== 8'h00) begin
            errors++; $display("FAIL flush: empty=%b tx=%h, want empty=1 tx=00", fifo_empty_i, s_tx);
        end
    endtask

    task automatic test_underflow_status;
        push(8'hB5);
        slot(8'h10);
        slot(8'h02);
        slot(8'hFF);
        checks++;
        if (s_tx !== 8'hB5 || s_nrd !== 1 || s_txat !== 5) begin
            errors++; $display("FAIL uf_byte: tx=%h rd=%0d at=%0d, want tx=b5 rd=1 at=5", s_tx, s_nrd, s_txat);
        end
        slot(8'hFF);
        checks++;
        if (s_tx !== 8'h00 || s_nrd !== 0 || state_o !== 2'd0) begin
            errors++; $display("FAIL uf_fill: tx=%h rd=%0d st=%0d, want tx=00 rd=0 st=0", s_tx, s_nrd, state_o);
        end
        slot(8'h20);
        slot(8'h20);
        checks++;
        if (s_tx !== 8'h24 || s_txat !== 5) begin
            errors++; $display("FAIL uf_status: tx=%h at=%0d, want tx=24 at=5", s_tx, s_txat);
        end
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h04) begin
            errors++; $display("FAIL uf_status_clear: tx=%h, want 04", s_tx);
        end
    endtask

    task automatic test_errors_overflow;
        slot(8'h01);
        slot(8'h7E);
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL err_state: st=%0d, want 0", state_o);
        end
        fifo_overflow_i = 1'b1;
        @(negedge clk);
        fifo_overflow_i = 1'b0;
        slot(8'h20);
        slot(8'h02);
        checks++;
        if (s_tx !== 8'hD4) begin
            errors++; $display("FAIL err_ovf_status: tx=%h, want d4", s_tx);
        end
        slot(8'h20);
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h04) begin
            errors++; $display("FAIL err_ovf_clear: tx=%h, want 04", s_tx);
        end
    endtask

    task automatic test_flush_capture;
        slot(8'h01);
        push(8'hC1); push(8'hC2);
        slot(8'h03);
        checks++;
        if (fifo_empty_i !== 1'b1 || capture_en_o !== 1'b1) begin
            errors++; $display("FAIL flush_capture: empty=%b cap=%b, want empty=1 cap=1", fifo_empty_i, capture_en_o);
        end
        slot(8'h02);
    endtask

    task automatic test_len_wrap;
        int bad;
        bad = 0;
        slot(8'h10);
        slot(8'h00);
        for (int i = 0; i < 255; i++) begin
            slot(8'hFF);
            if (s_tx !== 8'h00 || s_ntx !== 1 || s_txat !== 5 || s_nrd !== 0) bad++;
        end
        checks++;
        if (bad !== 0 || state_o !== 2'd2) begin
            errors++; $display("FAIL wrap_255: bad_slots=%0d st=%0d, want bad_slots=0 st=2", bad, state_o);
        end
        slot(8'hFF);
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL wrap_256: st=%0d, want 0", state_o);
        end
        slot(8'h20);
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h24) begin
            errors++; $display("FAIL wrap_status: tx=%h, want 24", s_tx);
        end
    endtask

    task automatic test_reset_mid_burst;
        slot(8'h01);
        push(8'hD1); push(8'hD2);
        slot(8'h10);
        slot(8'h05);
        spi_busy_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_o !== 2'd2 || fifo_rd_en_o !== 1'b1 || capture_en_o !== 1'b1) begin
            errors++;
            $display("FAIL midburst_pre: st=%0d rd=%b cap=%b, want st=2 rd=1 cap=1", state_o, fifo_rd_en_o, capture_en_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_tx_data_o, spi_tx_valid_o, fifo_rd_en_o, fifo_clr_o, capture_en_o, state_o} !== 14'd0) begin
            errors++;
            $display("FAIL midburst_reset: tx=%h v=%b rd=%b clr=%b cap=%b st=%0d, want all 0",
                     spi_tx_data_o, spi_tx_valid_o, fifo_rd_en_o, fifo_clr_o, capture_en_o, state_o);
        end
        spi_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state_o !== 2'd0 || capture_en_o !== 1'b0) begin
            errors++; $display("FAIL midburst_release: st=%0d cap=%b, want st=0 cap=0", state_o, capture_en_o);
        end
        slot(8'h03);
    endtask

    task automatic test_watchdog;
        slot(8'h10);
        repeat (80) @(negedge clk);
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL wd_before: st=%0d, want 1", state_o);
        end
        repeat (30) @(negedge clk);
`ifdef SPI_STREAM_WATCHDOG_EN
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL wd_timeout: st=%0d, want 0", state_o);
        end
        slot(8'h20);
        slot(8'h02);
        checks++;
        if (s_tx !== 8'h14) begin
            errors++; $display("FAIL wd_status: tx=%h, want 14", s_tx);
        end
`else
        checks++;
        if (state_o !== 2'd1) begin
            errors++; $display("FAIL wd_absent: st=%0d, want 1", state_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_burst();
        test_underflow_status();
        test_errors_overflow();
        test_flush_capture();
        test_len_wrap();
        test_reset_mid_burst();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
